// File: rtl/note_highway.sv
`default_nettype none
// ============================================================================
//  Module   : note_highway
//  Purpose  : Scrolling NUM_ROWS x NUM_LANES note grid with raster generator
//             and per-pixel colour for a VGA adapter. Rows are loaded from a
//             valid/ready note stream, scrolling can be paused, bottom-row
//             notes inside the hit zone are reported, and hit notes can be
//             cleared per lane.
//  Ports    : clk, reset       - clock, synchronous active-high reset
//             tick, pause      - scroll enable pulse, scroll freeze
//             note_data/valid  - next row of notes offered by the sequencer
//             note_ready       - row-load strobe (combinational)
//             hit_clear        - clear bottom-row note in flagged lanes
//             x, y             - raster coordinates
//             colour           - pixel colour for the previous cycle's (x,y)
//             hit_lanes        - bottom-row notes inside the hit zone
//             row_shift        - one-cycle pulse after each grid advance
//             underrun         - sticky: a row load found note_valid low
//  Revision : 1.0 - initial release
// ============================================================================
module note_highway #(
  parameter int SCREEN_W  = 320,
  parameter int SCREEN_H  = 240,
  parameter int NUM_LANES = 4,
  parameter int NUM_ROWS  = 11,
  parameter int ROW_PITCH = 20,
  parameter int NOTE_H    = 10,
  parameter int SUBSTEPS  = 5,
  parameter int STEP_PX   = 4,
  parameter int LANE_X0   = 123,
  parameter int LANE_W    = 16,
  parameter int BORDER_W  = 2,
  parameter int HIT_Y     = 220,
  parameter int HIT_WIN   = 8,
  // lane 0 sits in the LSBs: lane0=100, lane1=011, lane2=110, lane3=101
  parameter logic [3*NUM_LANES-1:0] LANE_COLOURS = {3'b101, 3'b110, 3'b011, 3'b100}
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 pause,
  input  logic [NUM_LANES-1:0] note_data,
  input  logic                 note_valid,
  output logic                 note_ready,
  input  logic [NUM_LANES-1:0] hit_clear,
  output logic [8:0]           x,
  output logic [7:0]           y,
  output logic [2:0]           colour,
  output logic [NUM_LANES-1:0] hit_lanes,
  output logic                 row_shift,
  output logic                 underrun
);

  localparam int SUB_W = (SUBSTEPS > 1) ? $clog2(SUBSTEPS) : 1;
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SUBSTEPS - 1);
  localparam int BOT = NUM_ROWS - 1;

  logic [SUB_W-1:0]     sub;
  logic [8:0]           offset;
  logic [NUM_LANES-1:0] grid [NUM_ROWS];

  logic                 adv;
  logic                 shift;
  logic                 in_zone;
  logic [2:0]           pix;

  // colour-path scratch, all in 32-bit arithmetic so note extents cannot wrap
  int                   xi;
  int                   yi;
  int                   r;
  int                   top;
  int                   xs;
  logic [NUM_LANES-1:0] sel;

  // Ticks arriving while paused are simply lost.
  assign adv        = tick & ~pause;
  assign shift      = adv && (sub == SUB_LAST);
  assign note_ready = shift;

  assign in_zone = (BOT * ROW_PITCH + int'(offset) + NOTE_H) > (HIT_Y - HIT_WIN);

  always_comb begin
    pix = 3'b111;
    xi  = int'(x);
    yi  = int'(y);
    r   = yi / ROW_PITCH;
    sel = '0;
    for (int i = 0; i < NUM_ROWS; i++) begin
      if (r == i) sel = grid[i];
    end
    top = r * ROW_PITCH + int'(offset);
    xs  = 0;
    for (int l = 0; l < NUM_LANES; l++) begin
      xs = LANE_X0 + BORDER_W + l * (LANE_W + BORDER_W);
      if (xi >= xs - BORDER_W && xi < xs) begin
        pix = 3'b000;
      end else if (xi >= xs && xi < xs + LANE_W) begin
        if (yi == HIT_Y || yi == HIT_Y + 1)
          pix = 3'b000;
        else if (sel[l] && yi >= top && yi < top + NOTE_H && yi < HIT_Y - 2)
          pix = LANE_COLOURS[3*l +: 3];
        else
          pix = 3'b111;
      end
    end
    // closing border to the right of the last lane
    if (xi >= LANE_X0 + NUM_LANES * (LANE_W + BORDER_W) &&
        xi <  LANE_X0 + NUM_LANES * (LANE_W + BORDER_W) + BORDER_W)
      pix = 3'b000;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x         <= '0;
      y         <= '0;
      colour    <= '0;
      sub       <= '0;
      offset    <= '0;
      hit_lanes <= '0;
      row_shift <= 1'b0;
      underrun  <= 1'b0;
      for (int i = 0; i < NUM_ROWS; i++) grid[i] <= '0;
    end else begin
      if (x == 9'(SCREEN_W - 1)) begin
        x <= '0;
        y <= (y == 8'(SCREEN_H - 1)) ? 8'd0 : y + 8'd1;
      end else begin
        x <= x + 9'd1;
      end

      colour    <= pix;
      row_shift <= shift;
      hit_lanes <= in_zone ? grid[BOT] : '0;

      if (shift) begin
        // the shift owns the bottom row this cycle, so hit_clear is dropped
        sub    <= '0;
        offset <= '0;
        for (int i = 1; i < NUM_ROWS; i++) grid[i] <= grid[i-1];
        grid[0] <= note_valid ? note_data : '0;
        if (!note_valid) underrun <= 1'b1;
      end else begin
        if (adv) begin
          sub    <= sub + SUB_W'(1);
          offset <= offset + 9'(STEP_PX);
        end
        grid[BOT] <= grid[BOT] & ~hit_clear;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_note_highway.sv
`default_nettype none
// ============================================================================
//  Module   : tb_note_highway
//  Purpose  : Self-checking bench for note_highway: raster sweep, row load,
//             scrolling, pause/underrun, hit zone/clear and clear-vs-shift.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_note_highway;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       pause = 1'b0;
  logic       note_valid = 1'b0;
  logic [3:0] note_data = 4'b0;
  logic [3:0] hit_clear = 4'b0;
  logic       note_ready;
  logic [8:0] x;
  logic [7:0] y;
  logic [2:0] colour;
  logic [3:0] hit_lanes;
  logic       row_shift;
  logic       underrun;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int         px;
    int         py;
    logic [2:0] col;
  } pix_t;

  pix_t sb[$];

  always #5 clk = ~clk;

  note_highway dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .pause      (pause),
    .note_data  (note_data),
    .note_valid (note_valid),
    .note_ready (note_ready),
    .hit_clear  (hit_clear),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .hit_lanes  (hit_lanes),
    .row_shift  (row_shift),
    .underrun   (underrun)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      step();
    end
    tick = 1'b0;
  endtask

  // Advance until the cycle after (tx,ty) was presented; colour then belongs to it.
  task automatic wait_pix(input int tx, input int ty, output bit found);
    int sx;
    int sy;
    found = 1'b0;
    for (int n = 0; n < 80000 && !found; n++) begin
      sx = int'(x);
      sy = int'(y);
      step();
      if (sx == tx && sy == ty) found = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    vectors++;
    if (x !== 9'd0 || y !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_xy: got (%0d,%0d) want (0,0)", x, y);
    end
    vectors++;
    if (colour !== 3'b000 || hit_lanes !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_colour_hit: got colour=%b hit=%b want 000/0000", colour, hit_lanes);
    end
    vectors++;
    if (row_shift !== 1'b0 || underrun !== 1'b0 || note_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got shift=%b under=%b ready=%b want 0/0/0",
               row_shift, underrun, note_ready);
    end
    reset = 1'b0;
  endtask

  task automatic test_hit();
    note_valid = 1'b1;
    note_data  = 4'b1000;
    do_ticks(5);
    note_data  = 4'b0000;
    do_ticks(50);              // 1000 now in the bottom row, offset 0
    step();
    vectors++;
    if (hit_lanes !== 4'b0000) begin
      miscompares++;
      $display("FAIL hit_offset0: got %b want 0000", hit_lanes);
    end
    do_ticks(1);               // offset 4
    step();
    vectors++;
    if (hit_lanes !== 4'b1000) begin
      miscompares++;
      $display("FAIL hit_offset4: got %b want 1000", hit_lanes);
    end
    sb.push_back('{179, 203, 3'b111});
    sb.push_back('{179, 205, 3'b101});
    while (sb.size() > 0) begin
      pix_t e;
      bit   ok;
      e = sb.pop_front();
      wait_pix(e.px, e.py, ok);
      vectors++;
      if (!ok) begin
        miscompares++;
        $display("FAIL hit_pix_timeout: pixel (%0d,%0d) never presented", e.px, e.py);
      end else if (colour !== e.col) begin
        miscompares++;
        $display("FAIL hit_pix (%0d,%0d): got %b want %b", e.px, e.py, colour, e.col);
      end
    end
    hit_clear = 4'b1000;
    step();
    hit_clear = 4'b0000;
    vectors++;
    if (hit_lanes !== 4'b1000) begin
      miscompares++;
      $display("FAIL hit_clear_latency: got %b want 1000", hit_lanes);
    end
    step();
    vectors++;
    if (hit_lanes !== 4'b0000) begin
      miscompares++;
      $display("FAIL hit_cleared: got %b want 0000", hit_lanes);
    end
    sb.push_back('{179, 210, 3'b111});
    while (sb.size() > 0) begin
      pix_t e;
      bit   ok;
      e = sb.pop_front();
      wait_pix(e.px, e.py, ok);
      vectors++;
      if (!ok) begin
        miscompares++;
        $display("FAIL hit_pix_timeout: pixel (%0d,%0d) never presented", e.px, e.py);
      end else if (colour !== e.col) begin
        miscompares++;
        $display("FAIL hit_pix (%0d,%0d): got %b want %b", e.px, e.py, colour, e.col);
      end
    end
  endtask

  // One full frame plus the wrap; the hit scenario runs alongside because
  // its bottom-row pixels only come by late in the frame.
  task automatic test_raster();
    do_reset();
    fork
      begin
        int mx = 0;
        int my = 0;
        int shown = 0;
        for (int i = 0; i <= 76800; i++) begin
          vectors++;
          if (x !== 9'(mx) || y !== 8'(my)) begin
            miscompares++;
            if (shown < 10)
              $display("FAIL raster cycle %0d: got (%0d,%0d) want (%0d,%0d)", i, x, y, mx, my);
            shown++;
          end
          if (mx == 319) begin
            mx = 0;
            my = (my == 239) ? 0 : my + 1;
          end else begin
            mx++;
          end
          step();
        end
      end
      test_hit();
    join
  endtask

  task automatic test_load();
    do_reset();
    note_valid = 1'b1;
    note_data  = 4'b0101;
    for (int i = 0; i < 5; i++) begin
      tick = 1'b1;
      #1;
      vectors++;
      if (note_ready !== (i == 4)) begin
        miscompares++;
        $display("FAIL load_ready tick %0d: got %b want %b", i, note_ready, (i == 4));
      end
      step();
    end
    tick = 1'b0;
    note_data = 4'b1111;       // not a shift cycle: must be ignored
    vectors++;
    if (row_shift !== 1'b1) begin
      miscompares++;
      $display("FAIL load_row_shift: got %b want 1", row_shift);
    end
    step();
    vectors++;
    if (row_shift !== 1'b0 || underrun !== 1'b0) begin
      miscompares++;
      $display("FAIL load_pulse_end: got shift=%b under=%b want 0/0", row_shift, underrun);
    end
    sb.push_back('{125, 0, 3'b100});
    sb.push_back('{143, 0, 3'b111});
    for (int yy = 1; yy <= 9; yy++) sb.push_back('{125, yy, 3'b100});
    sb.push_back('{125, 10, 3'b111});
    while (sb.size() > 0) begin
      pix_t e;
      bit   ok;
      e = sb.pop_front();
      wait_pix(e.px, e.py, ok);
      vectors++;
      if (!ok) begin
        miscompares++;
        $display("FAIL load_pix_timeout: pixel (%0d,%0d) never presented", e.px, e.py);
      end else if (colour !== e.col) begin
        miscompares++;
        $display("FAIL load_pix (%0d,%0d): got %b want %b", e.px, e.py, colour, e.col);
      end
    end
  endtask

  task automatic test_scroll();
    do_reset();
    note_valid = 1'b1;
    note_data  = 4'b0101;
    do_ticks(7);               // load, then offset 8
    sb.push_back('{125,  7, 3'b111});
    sb.push_back('{123,  8, 3'b000});
    sb.push_back('{124,  8, 3'b000});
    sb.push_back('{125,  8, 3'b100});
    sb.push_back('{141,  8, 3'b000});
    sb.push_back('{161,  8, 3'b110});
    sb.push_back('{195,  8, 3'b000});
    sb.push_back('{197,  8, 3'b111});
    sb.push_back('{125, 17, 3'b100});
    sb.push_back('{125, 18, 3'b111});
    while (sb.size() > 0) begin
      pix_t e;
      bit   ok;
      e = sb.pop_front();
      wait_pix(e.px, e.py, ok);
      vectors++;
      if (!ok) begin
        miscompares++;
        $display("FAIL scroll_pix_timeout: pixel (%0d,%0d) never presented", e.px, e.py);
      end else if (colour !== e.col) begin
        miscompares++;
        $display("FAIL scroll_pix (%0d,%0d): got %b want %b", e.px, e.py, colour, e.col);
      end
    end
  endtask

  task automatic test_underrun();
    do_reset();
    pause      = 1'b1;
    note_valid = 1'b1;
    note_data  = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      tick = 1'b1;
      #1;
      vectors++;
      if (note_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL pause_ready tick %0d: got %b want 0", i, note_ready);
      end
      step();
    end
    tick       = 1'b0;
    pause      = 1'b0;
    note_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick = 1'b1;
      #1;
      vectors++;
      if (note_ready !== (i == 4)) begin
        miscompares++;
        $display("FAIL underrun_ready tick %0d: got %b want %b", i, note_ready, (i == 4));
      end
      step();
    end
    tick = 1'b0;
    vectors++;
    if (underrun !== 1'b1) begin
      miscompares++;
      $display("FAIL underrun_set: got %b want 1", underrun);
    end
    sb.push_back('{125, 0, 3'b111});
    sb.push_back('{179, 0, 3'b111});
    while (sb.size() > 0) begin
      pix_t e;
      bit   ok;
      e = sb.pop_front();
      wait_pix(e.px, e.py, ok);
      vectors++;
      if (!ok) begin
        miscompares++;
        $display("FAIL underrun_pix_timeout: pixel (%0d,%0d) never presented", e.px, e.py);
      end else if (colour !== e.col) begin
        miscompares++;
        $display("FAIL underrun_pix (%0d,%0d): got %b want %b", e.px, e.py, colour, e.col);
      end
    end
    note_valid = 1'b1;
    note_data  = 4'b0001;
    do_ticks(10);
    vectors++;
    if (underrun !== 1'b1) begin
      miscompares++;
      $display("FAIL underrun_sticky: got %b want 1", underrun);
    end
  endtask

  task automatic test_conflict();
    do_reset();
    note_valid = 1'b1;
    note_data  = 4'b1000;
    do_ticks(5);
    note_data  = 4'b0110;
    do_ticks(5);
    note_data  = 4'b0000;
    do_ticks(45);              // bottom row 1000, row 9 holds 0110
    do_ticks(1);
    step();
    vectors++;
    if (hit_lanes !== 4'b1000) begin
      miscompares++;
      $display("FAIL conflict_pre: got %b want 1000", hit_lanes);
    end
    do_ticks(3);
    tick      = 1'b1;
    hit_clear = 4'b1111;
    #1;
    vectors++;
    if (note_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL conflict_shift_cycle: got ready=%b want 1", note_ready);
    end
    step();
    tick      = 1'b0;
    hit_clear = 4'b0000;
    do_ticks(1);
    step();
    vectors++;
    if (hit_lanes !== 4'b0110) begin
      miscompares++;
      $display("FAIL conflict_bottom: got %b want 0110", hit_lanes);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_raster();
    test_load();
    test_scroll();
    test_underrun();
    test_conflict();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
